// File: rtl/row_load_sched_pkg.sv
// Shared definitions for the row-load scheduler: default row-index width and FSM state encoding.
package row_load_sched_pkg;

  localparam int unsigned WSizeDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StReady,
    StDone
  } state_e;

endpackage

// File: rtl/row_load_sched_req_watchdog.sv
// Cycle counter for an outstanding row request; asserts expired on the TimeoutCyc-th enabled cycle.
module req_watchdog
  import row_load_sched_pkg::*;
#(
  parameter int unsigned TimeoutCyc = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TimeoutCyc) + 1;

  logic [CntW-1:0] cnt_q;

  // Count restarts from zero each time the request wait is entered.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = en && (cnt_q == CntW'(TimeoutCyc - 1));

endmodule

// File: rtl/row_load_sched.sv
// Row-load scheduler: preloads rows 0/1, then requests row cur+2 as each row finishes computing.
// Optional request watchdog enabled by defining ROW_REQ_TIMEOUT_EN.
module row_load_sched
  import row_load_sched_pkg::*;
#(
  parameter int unsigned W_SIZE      = WSizeDefault,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_SIZE-1:0] q_height,
  input  logic              q_start,
  input  logic              c_row_done,
  output logic              m_req_load,
  output logic [W_SIZE-1:0] m_req_row,
  input  logic              i_req_done,
  output logic              o_row_ready,
  output logic [W_SIZE-1:0] o_cur_row,
  output logic              o_rotate,
  output logic              o_pad_top,
  output logic              o_pad_bot,
  output logic              o_busy,
  output logic              o_layer_done,
  output logic              o_err
);

  localparam int unsigned XW = W_SIZE + 1;

  state_e            state_q, state_d;
  logic [W_SIZE-1:0] height_q, height_d;
  logic [W_SIZE-1:0] cur_row_q, cur_row_d;
  logic [W_SIZE-1:0] req_row_q, req_row_d;
  logic              rotate_q, rotate_d;
  logic              timeout;
  logic              row_done_ok;

  // Widened copies so height-1 and cur+2 never wrap.
  logic [XW-1:0] height_x, height_m1, cur_x, cur_p2;

  assign height_x  = {1'b0, height_q};
  assign height_m1 = height_x - XW'(1);
  assign cur_x     = {1'b0, cur_row_q};
  assign cur_p2    = cur_x + XW'(2);

  // The rotate cycle masks READY so a held c_row_done cannot count twice.
  assign row_done_ok = (state_q == StReady) && !rotate_q && c_row_done;

  always_comb begin
    state_d   = state_q;
    height_d  = height_q;
    cur_row_d = cur_row_q;
    req_row_d = req_row_q;
    rotate_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (q_start) begin
          height_d  = q_height;
          cur_row_d = '0;
          req_row_d = '0;
          state_d   = (q_height != '0) ? StReq : StDone;
        end
      end
      StReq: begin
        state_d = StWait;
      end
      StWait: begin
        if (i_req_done) begin
          if ((req_row_q == '0) && (height_q > W_SIZE'(1))) begin
            req_row_d = W_SIZE'(1);
            state_d   = StReq;
          end else begin
            state_d = StReady;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StReady: begin
        if (row_done_ok) begin
          rotate_d  = 1'b1;
          cur_row_d = cur_row_q + W_SIZE'(1);
          if (cur_x == height_m1) begin
            state_d = StDone;
          end else if (cur_p2 < height_x) begin
            req_row_d = cur_row_q + W_SIZE'(2);
            state_d   = StReq;
          end else begin
            state_d = StReady;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      height_q  <= '0;
      cur_row_q <= '0;
      req_row_q <= '0;
      rotate_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      height_q  <= height_d;
      cur_row_q <= cur_row_d;
      req_row_q <= req_row_d;
      rotate_q  <= rotate_d;
    end
  end

`ifdef ROW_REQ_TIMEOUT_EN
  logic err_q;

  req_watchdog #(
    .TimeoutCyc(TIMEOUT_CYC)
  ) u_req_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == StWait),
    .expired(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == StWait) && !i_req_done && timeout) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout            = 1'b0;
  assign o_err              = 1'b0;
`endif

  assign m_req_load   = (state_q == StReq);
  assign m_req_row    = req_row_q;
  assign o_row_ready  = (state_q == StReady) && !rotate_q;
  assign o_cur_row    = cur_row_q;
  assign o_rotate     = rotate_q;
  assign o_busy       = (state_q != StIdle);
  assign o_layer_done = (state_q == StDone);
  assign o_pad_top    = o_busy && (cur_x == '0);
  assign o_pad_bot    = o_busy && (cur_x == height_m1);

endmodule
